node: RTL and testbench
=======================

Name: node

Overview:
- One point mass of the segmented rope simulation, implemented as registered 32-bit signed fixed-point X/Y position state.
- Each node is instantiated once per rope position and driven by a rotating one-hot phase token.
- On its integrate phase the node advances itself with damped Verlet integration plus gravity. Node 1 is the anchor and snaps to the mouse instead.
- On its constrain phase the node loads the distance-corrected position computed by the neighbouring constraint solver.

Parameters:
- NODE_ID, 1: global rope index, 1-based. NODE_ID==1 is the mouse-driven anchor.
- INIT_X, 32'h0064_0000: reset X position (Q16.16, 100.0).
- INIT_Y, 32'h000A_0000: reset Y position of node 1 (Q16.16, 10.0).
- SPACING, 32'h000A_0000: rest vertical spacing between consecutive nodes at reset (10.0).
- GRAVITY, 32'h0000_8000: Y acceleration added per integrate step (0.5).
- DAMP_SHIFT, 6: velocity damping; damped velocity = vel - (vel >>> DAMP_SHIFT).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- integrate_en  in  1  phase-A token: perform one integration step this cycle.
- constrain_en  in  1  phase-B token: load the constrained position this cycle.
- new_x  in  32  constrained X from the constraint solver (Q16.16 signed).
- new_y  in  32  constrained Y from the constraint solver.
- x_mouse  in  32  mouse X (Q16.16); used only when NODE_ID==1.
- y_mouse  in  32  mouse Y; used only when NODE_ID==1.
- x_pos  out  32  current X position, registered.
- y_pos  out  32  current Y position, registered.

Behaviour:
- Internal state: cur_x, cur_y (driven onto x_pos, y_pos) and prev_x, prev_y. All four are registers; there is no combinational path from inputs to outputs.
- Reset (reset==0 at a rising clk edge):
  - cur_x = prev_x = INIT_X.
  - cur_y = prev_y = INIT_Y + (NODE_ID-1)*SPACING, computed at elaboration.
  - Reset overrides both enables.
- Priority when reset==1: integrate_en > constrain_en > hold. If both enables are high, only the integration is performed.
- Integrate, NODE_ID==1:
  - cur_x <= x_mouse, cur_y <= y_mouse.
  - prev <= old cur.
- Integrate, NODE_ID>1:
  - vx = cur_x - prev_x; vy = cur_y - prev_y.
  - dvx = vx - (vx >>> DAMP_SHIFT); dvy likewise. Arithmetic shift.
  - cur_x <= cur_x + dvx.
  - cur_y <= cur_y + dvy + GRAVITY.
  - prev <= old cur.
- Constrain, NODE_ID>1: cur_x <= new_x, cur_y <= new_y. prev is unchanged, so the correction feeds into the next step's velocity.
- Constrain, NODE_ID==1: ignored; the state holds.
- Neither enable: all state holds.
- Arithmetic:
  - 32-bit two's complement with wrap-around on overflow; no saturation.
  - Intermediates are computed at 32 bits and truncated.
- Latency: an update is visible on x_pos/y_pos the cycle after the enabling edge, i.e. one register stage.
- Reset mid-run: any pending update is discarded and the state returns to the reset values on that edge.
- The enables are level-sampled each edge. Holding integrate_en high for N cycles performs N steps.

Test Plan:
- Reset, NODE_ID=3 -> x_pos=32'h0064_0000, y_pos=32'h001E_0000. Both are held while reset==0 regardless of enables.
- NODE_ID=3, one integrate pulse after reset -> y_pos=32'h001E_8000, x_pos unchanged. A second pulse -> y_pos=32'h001F_7E00 (damped vy=32'h7E00 plus gravity).
- NODE_ID=1, x_mouse=32'h00C8_0000, y_mouse=32'h0032_0000, integrate pulse -> x_pos/y_pos equal the mouse values next cycle. A constrain pulse with new_x=32'h1234_5678 -> no change.
- NODE_ID=3, constrain pulse with new_x=32'h1234_5678, new_y=32'h0000_1000 -> outputs equal these. A following integrate -> x = new_x + damped(new_x - INIT_X).
- Both enables high, NODE_ID=3, from reset -> y_pos=32'h001E_8000; new_x/new_y are ignored.
- NODE_ID=2, cur_y near 32'h7FFF_F000, integrate -> Y wraps negative with no saturation. Reset asserted mid-sequence -> reset values on the next edge.

Source files
------------

// File: rtl/node.sv
// Purpose : one point mass of a segmented rope; damped Verlet + gravity on the
//           integrate token, loads solver-corrected position on the constrain token.
// Latency : one cycle; an update is visible on x_pos/y_pos after the enabling edge.
// Backpressure: none; enables are level-sampled every edge, each high edge is one step.
//
// Ports:
//   clk                  rising-edge clock
//   reset                synchronous active-low reset, overrides both enables
//   integrate_en         phase-A token: one integration step (wins over constrain_en)
//   constrain_en         phase-B token: load new_x/new_y (ignored by the anchor)
//   new_x, new_y         constrained position from the solver, Q16.16 signed
//   x_mouse, y_mouse     mouse position, drives the anchor (NODE_ID==1) only
//   x_pos, y_pos         registered current position, Q16.16 signed
module node #(
    parameter int          NODE_ID    = 1,
    parameter logic [31:0] INIT_X     = 32'h0064_0000,
    parameter logic [31:0] INIT_Y     = 32'h000A_0000,
    parameter logic [31:0] SPACING    = 32'h000A_0000,
    parameter logic [31:0] GRAVITY    = 32'h0000_8000,
    parameter int          DAMP_SHIFT = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        integrate_en,
    input  logic        constrain_en,
    input  logic [31:0] new_x,
    input  logic [31:0] new_y,
    input  logic [31:0] x_mouse,
    input  logic [31:0] y_mouse,
    output logic [31:0] x_pos,
    output logic [31:0] y_pos
);

    localparam logic        IS_ANCHOR = (NODE_ID == 1);
    // Nodes hang in a vertical column at reset, SPACING apart.
    localparam logic [31:0] RESET_Y   = INIT_Y + 32'(NODE_ID - 1) * SPACING;

    logic [31:0] cur_x, cur_y, prev_x, prev_y;
    logic [31:0] cur_x_nxt, cur_y_nxt, prev_x_nxt, prev_y_nxt;

    // Velocity is implicit in (cur - prev); damping removes 1/2^DAMP_SHIFT of it.
    logic signed [31:0] vx, vy, dvx, dvy;

    always_comb begin
        vx  = $signed(cur_x - prev_x);
        vy  = $signed(cur_y - prev_y);
        dvx = vx - (vx >>> DAMP_SHIFT);
        dvy = vy - (vy >>> DAMP_SHIFT);
    end

    always_comb begin
        cur_x_nxt  = cur_x;
        cur_y_nxt  = cur_y;
        prev_x_nxt = prev_x;
        prev_y_nxt = prev_y;
        if (integrate_en) begin
            prev_x_nxt = cur_x;
            prev_y_nxt = cur_y;
            if (IS_ANCHOR) begin
                cur_x_nxt = x_mouse;
                cur_y_nxt = y_mouse;
            end else begin
                cur_x_nxt = cur_x + 32'(dvx);
                cur_y_nxt = cur_y + 32'(dvy) + GRAVITY;
            end
        end else if (constrain_en && !IS_ANCHOR) begin
            // prev is left alone so the correction shows up as velocity next step.
            cur_x_nxt = new_x;
            cur_y_nxt = new_y;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cur_x  <= INIT_X;
            cur_y  <= RESET_Y;
            prev_x <= INIT_X;
            prev_y <= RESET_Y;
        end else begin
            cur_x  <= cur_x_nxt;
            cur_y  <= cur_y_nxt;
            prev_x <= prev_x_nxt;
            prev_y <= prev_y_nxt;
        end
    end

    assign x_pos = cur_x;
    assign y_pos = cur_y;

endmodule

// File: tb/tb_node.sv
// Purpose : checks anchor (NODE_ID=1) and two hanging nodes (2, 3) against a
//           reference model through an expected-value queue.
// Latency : expected values are popped one edge after the stimulus that made them.
// Backpressure: n/a.
module tb_node;

    localparam logic [31:0] INIT_X  = 32'h0064_0000;
    localparam logic [31:0] INIT_Y  = 32'h000A_0000;
    localparam logic [31:0] SPACING = 32'h000A_0000;
    localparam logic [31:0] GRAVITY = 32'h0000_8000;

    logic        clk = 1'b0;
    logic        reset;
    logic        integrate_en, constrain_en;
    logic [31:0] new_x, new_y, x_mouse, y_mouse;
    logic [31:0] x_pos [1:3];
    logic [31:0] y_pos [1:3];

    always #5 clk = ~clk;

    node #(.NODE_ID(1)) u_n1 (
        .clk(clk), .reset(reset), .integrate_en(integrate_en), .constrain_en(constrain_en),
        .new_x(new_x), .new_y(new_y), .x_mouse(x_mouse), .y_mouse(y_mouse),
        .x_pos(x_pos[1]), .y_pos(y_pos[1]));
    node #(.NODE_ID(2)) u_n2 (
        .clk(clk), .reset(reset), .integrate_en(integrate_en), .constrain_en(constrain_en),
        .new_x(new_x), .new_y(new_y), .x_mouse(x_mouse), .y_mouse(y_mouse),
        .x_pos(x_pos[2]), .y_pos(y_pos[2]));
    node #(.NODE_ID(3)) u_n3 (
        .clk(clk), .reset(reset), .integrate_en(integrate_en), .constrain_en(constrain_en),
        .new_x(new_x), .new_y(new_y), .x_mouse(x_mouse), .y_mouse(y_mouse),
        .x_pos(x_pos[3]), .y_pos(y_pos[3]));

    typedef struct {
        string       tag;
        logic [31:0] x [1:3];
        logic [31:0] y [1:3];
    } exp_t;

    exp_t exp_q [$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state.
    logic [31:0] m_cx [1:3];
    logic [31:0] m_cy [1:3];
    logic [31:0] m_px [1:3];
    logic [31:0] m_py [1:3];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] damp(input logic [31:0] v);
        logic signed [31:0] s;
        s = $signed(v);
        return v - 32'(s >>> 6);
    endfunction

    task automatic model_step(input logic rst, input logic ie, input logic ce,
                              input logic [31:0] nx, input logic [31:0] ny,
                              input logic [31:0] mx, input logic [31:0] my);
        for (int id = 1; id <= 3; id++) begin
            logic [31:0] ox, oy;
            ox = m_cx[id];
            oy = m_cy[id];
            if (!rst) begin
                m_cx[id] = INIT_X;
                m_cy[id] = INIT_Y + 32'(id - 1) * SPACING;
                m_px[id] = m_cx[id];
                m_py[id] = m_cy[id];
            end else if (ie) begin
                if (id == 1) begin
                    m_cx[id] = mx;
                    m_cy[id] = my;
                end else begin
                    m_cx[id] = ox + damp(ox - m_px[id]);
                    m_cy[id] = oy + damp(oy - m_py[id]) + GRAVITY;
                end
                m_px[id] = ox;
                m_py[id] = oy;
            end else if (ce && id != 1) begin
                m_cx[id] = nx;
                m_cy[id] = ny;
            end
        end
    endtask

    // Drive one edge, push the model's prediction, pop and compare after the edge.
    task automatic step(input string tag, input logic rst, input logic ie, input logic ce,
                        input logic [31:0] nx, input logic [31:0] ny,
                        input logic [31:0] mx, input logic [31:0] my);
        exp_t e;
        @(negedge clk);
        reset = rst; integrate_en = ie; constrain_en = ce;
        new_x = nx; new_y = ny; x_mouse = mx; y_mouse = my;
        model_step(rst, ie, ce, nx, ny, mx, my);
        e.tag = tag;
        for (int id = 1; id <= 3; id++) begin
            e.x[id] = m_cx[id];
            e.y[id] = m_cy[id];
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        for (int id = 1; id <= 3; id++) begin
            chk($sformatf("%s.x%0d", e.tag, id), x_pos[id], e.x[id]);
            chk($sformatf("%s.y%0d", e.tag, id), y_pos[id], e.y[id]);
        end
    endtask

    initial begin
        reset = 1'b0; integrate_en = 1'b0; constrain_en = 1'b0;
        new_x = '0; new_y = '0; x_mouse = '0; y_mouse = '0;

        // Reset held with both enables active: reset values must stick.
        step("rst0", 1'b0, 1'b1, 1'b1, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444);
        step("rst1", 1'b0, 1'b1, 1'b1, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444);
        chk("rst_x3", x_pos[3], 32'h0064_0000);
        chk("rst_y3", y_pos[3], 32'h001E_0000);
        chk("rst_y1", y_pos[1], 32'h000A_0000);

        // Two integrate pulses: gravity then damped velocity plus gravity.
        step("int1", 1'b1, 1'b1, 1'b0, '0, '0, 32'h00C8_0000, 32'h0032_0000);
        chk("int1_y3", y_pos[3], 32'h001E_8000);
        chk("int1_x3", x_pos[3], 32'h0064_0000);
        chk("anchor_x", x_pos[1], 32'h00C8_0000);
        chk("anchor_y", y_pos[1], 32'h0032_0000);
        step("int2", 1'b1, 1'b1, 1'b0, '0, '0, 32'h00C8_0000, 32'h0032_0000);
        chk("int2_y3", y_pos[3], 32'h001F_7E00);

        // Constrain: hanging nodes load, anchor ignores it.
        step("con", 1'b1, 1'b0, 1'b1, 32'h1234_5678, 32'h0000_1000, 32'h0, 32'h0);
        chk("con_x3", x_pos[3], 32'h1234_5678);
        chk("con_y3", y_pos[3], 32'h0000_1000);
        chk("con_anchor", x_pos[1], 32'h00C8_0000);
        step("int3", 1'b1, 1'b1, 1'b0, '0, '0, 32'h0010_0000, 32'h0020_0000);
        chk("int3_x3", x_pos[3], 32'h23BD_6B97);

        // Hold.
        step("hold", 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0, 32'h0);

        // Reset, then both enables: integrate wins, new_x/new_y ignored.
        step("rst2", 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
        step("both", 1'b1, 1'b1, 1'b1, 32'h5555_5555, 32'h6666_6666, 32'h0, 32'h0);
        chk("both_y3", y_pos[3], 32'h001E_8000);
        chk("both_x3", x_pos[3], 32'h0064_0000);

        // Overflow: push node 2 near the positive limit then integrate.
        step("wcon", 1'b1, 1'b0, 1'b1, 32'h0064_0000, 32'h7FFF_F000, 32'h0, 32'h0);
        step("wint", 1'b1, 1'b1, 1'b0, '0, '0, 32'h0, 32'h0);
        chk("wrap_y2", y_pos[2], 32'hFDEC_B040);

        // Random enables and values.
        for (int i = 0; i < 40; i++) begin
            step($sformatf("rnd%0d", i), 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom, $urandom, $urandom, $urandom);
        end

        // Reset mid-run with integrate pending.
        step("rst3", 1'b0, 1'b1, 1'b0, '0, '0, 32'h0ABC_0000, 32'h0DEF_0000);
        chk("rst3_y2", y_pos[2], 32'h0014_0000);
        chk("rst3_x1", x_pos[1], 32'h0064_0000);

        for (int i = 0; i < 10; i++) begin
            step($sformatf("tail%0d", i), 1'b1, 1'b1, 1'b0, '0, '0, 32'h0001_0000 * i, 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
